// File: rtl/progmem_reader_if.sv
// -----------------------------------------------------------------------------
// progmem_reader_if
// Bundles the program-memory read port and the output word stream of
// progmem_reader.
//   mst_address     word address of the current read (initiator -> memory)
//   mst_read        read request, held until accepted
//   mst_readdata    returned word (memory -> initiator)
//   mst_response    0 = OK, anything else = error
//   mst_waitrequest memory stall; a read is accepted when it is low
//   out_data        head word of the output buffer
//   out_valid       output buffer non-empty
//   out_ready       consumer takes the head word when high with out_valid
// Modports: master = reader side, slave = memory/consumer side.
// -----------------------------------------------------------------------------
interface progmem_reader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [ADDR_W-1:0] mst_address;
  logic              mst_read;
  logic [31:0]       mst_readdata;
  logic [1:0]        mst_response;
  logic              mst_waitrequest;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mst_address,
    output mst_read,
    input  mst_readdata,
    input  mst_response,
    input  mst_waitrequest,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  mst_address,
    input  mst_read,
    output mst_readdata,
    output mst_response,
    output mst_waitrequest,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/progmem_reader.sv
// -----------------------------------------------------------------------------
// progmem_reader
// Burst reader for the program memory. On start it fetches word_count words
// beginning at start_addr, one read at a time with a one-cycle gap between
// reads, and queues the returned words in a small FIFO for a valid/ready
// consumer. A read is only issued while the FIFO has room, so the consumer
// back-pressures the memory side without ever losing a word.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle burst request (ignored unless idle)
//   start_addr        first word address
//   word_count        number of words (0..2^ADDR_W)
//   busy              burst in progress
//   done              one-cycle pulse at end of burst
//   error             sticky bad-response/timeout flag, cleared by next start
//   bus               progmem_reader_if.master (memory port + output stream)
//
// Build option:
//   PROGMEM_READER_TIMEOUT_EN  adds an 8-bit stall counter; a read stalled by
//                              waitrequest for 255 cycles is abandoned with
//                              error set. Without it a read waits forever.
// -----------------------------------------------------------------------------
module progmem_reader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  progmem_reader_if.master  bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WC_W  = ADDR_W + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  // Control state
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WC_W-1:0]   remain_q, remain_d;
  logic              read_q, read_d;
  logic              error_d;

  // Output FIFO
  logic [FIFO_DEPTH-1:0][31:0] mem_q;
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        valid_q;

  logic accept_c, resp_ok_c, push_c, pop_c, tmo_hit_c;

  assign accept_c  = read_q & ~bus.mst_waitrequest;
  assign resp_ok_c = (bus.mst_response == 2'b00);
  assign push_c    = accept_c & resp_ok_c;
  assign pop_c     = valid_q & bus.out_ready;
  assign count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

`ifdef PROGMEM_READER_TIMEOUT_EN
  // Consecutive stalled-read cycles; the 255th stalled cycle gives up.
  logic [7:0] tmo_q, tmo_d;

  assign tmo_hit_c = read_q & bus.mst_waitrequest & (tmo_q == 8'd254);

  always_comb begin
    tmo_d = 8'd0;
    if ((state_q == REQ) && read_q && bus.mst_waitrequest && !tmo_hit_c) begin
      tmo_d = tmo_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Next-state logic for the burst sequencer
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    error_d  = error;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = start_addr;
          remain_d = word_count;
          error_d  = 1'b0;
          state_d  = (word_count == '0) ? FINISH : REQ;
        end
      end
      REQ: begin
        if (accept_c) begin
          if (resp_ok_c) begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - WC_W'(1);
            state_d  = GAP;
          end else begin
            error_d  = 1'b1;
            remain_d = '0;
            state_d  = FINISH;
          end
        end else if (tmo_hit_c) begin
          error_d  = 1'b1;
          remain_d = '0;
          state_d  = FINISH;
        end
      end
      GAP: begin
        state_d = (remain_q == '0) ? FINISH : REQ;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An outstanding read is held until accepted; a new one needs FIFO room
    // as it will stand after this cycle's push/pop.
    read_d = (state_d == REQ) && (read_q || (count_d < CNT_W'(FIFO_DEPTH)));
  end

  // Sequencer registers and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      read_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      read_q   <= read_d;
      busy     <= (state_d != IDLE);
      done     <= (state_d == FINISH);
      error    <= error_d;
    end
  end

  // Output FIFO; a push never meets a full FIFO because a read is only
  // launched with room available and only one read is ever outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= bus.mst_readdata;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign bus.mst_read    = read_q;
  assign bus.mst_address = addr_q;
  assign bus.out_data    = mem_q[rd_ptr_q];
  assign bus.out_valid   = valid_q;

endmodule
